// File: rtl/field_serializer.sv
// Protobuf field serializer: accepts one table entry, fetches the field word from memory and
// streams the wire bytes (tag varint, then value) one per cycle with valid/ready backpressure.
module field_serializer #(
  parameter int ADDR_W     = 64,
  parameter int FIELD_ID_W = 29,
  parameter int LEN_W      = 32,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  entry_valid,
  input  logic [FIELD_ID_W-1:0] entry_field_id,
  input  logic [2:0]            entry_type,
  input  logic [ADDR_W-1:0]     entry_offset,
  input  logic [LEN_W-1:0]      entry_nested_len,
  input  logic [ADDR_W-1:0]     cpp_base_addr,
  output logic                  ser_ready,
  output logic                  ser_done,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [63:0]           mem_rdata,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      total_bytes,
  output logic                  err
);

  localparam logic [2:0] T_VARINT64 = 3'd0;
  localparam logic [2:0] T_VARINT32 = 3'd1;
  localparam logic [2:0] T_FIXED32  = 3'd2;
  localparam logic [2:0] T_FIXED64  = 3'd3;
  localparam logic [2:0] T_BOOL     = 3'd4;
  localparam logic [2:0] T_NESTED   = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_TAG, S_VAL, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_type;
  logic [ADDR_W-1:0]   r_addr;
  logic [63:0]         r_sh;     // bits still to be emitted for the current phase
  logic [63:0]         r_val;    // value staged while the tag is streaming
  logic [3:0]          r_cnt;    // fixed-width bytes remaining
  logic                r_err;
  logic [CNT_W-1:0]    r_total;

  logic                w_emit, w_acc, w_fixed, w_last;
  logic [7:0]          w_byte;

  function automatic logic [2:0] f_wire(input logic [2:0] t);
    case (t)
      T_FIXED32: f_wire = 3'd5;
      T_FIXED64: f_wire = 3'd1;
      T_NESTED:  f_wire = 3'd2;
      default:   f_wire = 3'd0;
    endcase
  endfunction

  assign w_emit  = (r_state == S_TAG) || (r_state == S_VAL);
  assign w_acc   = w_emit && out_ready;
  assign w_fixed = (r_state == S_VAL) && ((r_type == T_FIXED32) || (r_type == T_FIXED64));
  assign w_byte  = w_fixed ? r_sh[7:0] : {|r_sh[63:7], r_sh[6:0]};
  assign w_last  = w_fixed ? (r_cnt == 4'd1) : ~|r_sh[63:7];

  assign ser_ready   = (r_state == S_IDLE) && reset;
  assign ser_done    = (r_state == S_DONE);
  assign mem_req     = (r_state == S_REQ);
  assign mem_addr    = r_addr;
  assign out_valid   = w_emit;
  assign out_byte    = w_emit ? w_byte : 8'h00;
  assign total_bytes = r_total;
  assign err         = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (entry_valid) begin
        if (entry_field_id == '0)         w_next = S_DONE;
        else if (entry_type >= 3'd6)      w_next = S_DONE;
        else if (entry_type == T_NESTED)  w_next = S_TAG;
        else                              w_next = S_REQ;
      end
      S_REQ:   if (mem_gnt)         w_next = S_WAIT;
      S_WAIT:  if (mem_rvalid)      w_next = S_TAG;
      S_TAG:   if (w_acc && w_last) w_next = S_VAL;
      S_VAL:   if (w_acc && w_last) w_next = S_DONE;
      S_DONE:                       w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_type  <= '0;
      r_addr  <= '0;
      r_sh    <= '0;
      r_val   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_total <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) r_total <= r_total + CNT_W'(1);
      case (r_state)
        S_IDLE: if (entry_valid) begin
          r_type <= entry_type;
          r_addr <= cpp_base_addr + entry_offset;
          // tag is loaded up front; the value register is overwritten by the read for non-nested types
          r_sh   <= 64'({entry_field_id, f_wire(entry_type)});
          r_val  <= 64'(entry_nested_len);
          if ((entry_field_id != '0) && (entry_type >= 3'd6)) r_err <= 1'b1;
        end
        S_WAIT: if (mem_rvalid) begin
          case (r_type)
            T_VARINT32, T_FIXED32: r_val <= {32'h0, mem_rdata[31:0]};
            T_BOOL:                r_val <= {63'h0, |mem_rdata};
            default:               r_val <= mem_rdata;
          endcase
        end
        S_TAG: if (w_acc) begin
          if (w_last) begin
            r_sh  <= r_val;
            r_cnt <= (r_type == T_FIXED64) ? 4'd8 : 4'd4;
          end else begin
            r_sh  <= r_sh >> 7;
          end
        end
        S_VAL: if (w_acc) begin
          if (w_fixed) begin
            r_sh  <= r_sh >> 8;
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_sh  <= r_sh >> 7;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_field_serializer.sv
// Directed bench for field_serializer: acts as memory and byte sink, compares against
// hand-encoded protobuf byte sequences.
module tb_field_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        entry_valid;
  logic [28:0] entry_field_id;
  logic [2:0]  entry_type;
  logic [63:0] entry_offset;
  logic [31:0] entry_nested_len;
  logic [63:0] cpp_base_addr;
  logic        ser_ready, ser_done, mem_req, mem_gnt, mem_rvalid;
  logic [63:0] mem_addr, mem_rdata;
  logic [7:0]  out_byte;
  logic        out_valid, out_ready;
  logic [31:0] total_bytes;
  logic        err;

  field_serializer dut (
    .clk(clk), .reset(reset),
    .entry_valid(entry_valid), .entry_field_id(entry_field_id), .entry_type(entry_type),
    .entry_offset(entry_offset), .entry_nested_len(entry_nested_len), .cpp_base_addr(cpp_base_addr),
    .ser_ready(ser_ready), .ser_done(ser_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .total_bytes(total_bytes), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int          n_done, n_req, first_c, done_c, hold_bad, addr_bad, stall_left;
  logic [63:0] paddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, " nbytes"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  // Drive one entry and play memory + sink until ser_done has been seen (or abort via reset).
  task automatic run(input logic [28:0] fid, input logic [2:0] typ, input logic [63:0] off,
                     input logic [31:0] len, input logic [63:0] rd, input int gdly,
                     input int st_at, input int st_len, input int abort_at);
    logic gnt_prev, pstall;
    logic [7:0] pb;
    got.delete();
    n_done = 0; n_req = 0; first_c = -1; done_c = -1; hold_bad = 0; addr_bad = 0;
    paddr = '0; gnt_prev = 0; pstall = 0; pb = '0; stall_left = st_len;
    @(negedge clk);
    chk("ser_ready idle", 64'(ser_ready), 64'd1);
    entry_valid = 1; entry_field_id = fid; entry_type = typ; entry_offset = off;
    entry_nested_len = len; cpp_base_addr = 64'h100;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      // scramble entry inputs: they must be ignored outside IDLE
      entry_valid = 0; entry_field_id = 29'h7; entry_type = 3'd0;
      entry_offset = '1; entry_nested_len = '1; cpp_base_addr = 64'hdead;
      if (c == abort_at) begin
        reset = 0;
        #1;
        chk("abort out_valid", 64'(out_valid), 0);
        chk("abort out_byte", 64'(out_byte), 0);
        chk("abort mem_req", 64'(mem_req), 0);
        chk("abort mem_addr", mem_addr, 0);
        chk("abort total", 64'(total_bytes), 0);
        chk("abort err", 64'(err), 0);
        chk("abort ser_done", 64'(ser_done), 0);
        break;
      end
      mem_rvalid = gnt_prev;
      mem_rdata  = gnt_prev ? rd : 64'h0;
      gnt_prev = 0; mem_gnt = 0;
      if (mem_req) begin
        if (n_req > 0 && mem_addr !== paddr) addr_bad++;
        paddr = mem_addr;
        n_req++;
        if (n_req > gdly) begin mem_gnt = 1; gnt_prev = 1; end
      end
      if (pstall && (!out_valid || out_byte !== pb)) hold_bad++;
      pstall = 0;
      out_ready = 1;
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        if (got.size() == st_at && stall_left > 0) begin
          out_ready = 0; stall_left--; pstall = 1; pb = out_byte;
        end else got.push_back(out_byte);
      end
      if (ser_done) begin n_done++; if (done_c < 0) done_c = c; end
      if (done_c > 0 && c >= done_c + 2) break;
    end
    mem_gnt = 0; mem_rvalid = 0; out_ready = 1;
  endtask

  initial begin
    reset = 0; entry_valid = 0; entry_field_id = '0; entry_type = '0; entry_offset = '0;
    entry_nested_len = '0; cpp_base_addr = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 0);
    chk("rst mem_req", 64'(mem_req), 0);
    chk("rst ser_done", 64'(ser_done), 0);
    chk("rst total", 64'(total_bytes), 0);
    chk("rst mem_addr", mem_addr, 0);
    reset = 1;

    // 1: VARINT64 150 -> 08 96 01
    run(29'd1, 3'd0, 64'h8, 32'd0, 64'd150, 0, -1, 0, -1);
    exp_q = '{8'h08, 8'h96, 8'h01};
    chk_bytes("t1");
    chk("t1 mem_addr", paddr, 64'h108);
    chk("t1 n_req", 64'(n_req), 1);
    chk("t1 first", 64'(first_c), 3);
    chk("t1 done_c", 64'(done_c), 6);
    chk("t1 n_done", 64'(n_done), 1);
    chk("t1 total", 64'(total_bytes), 3);

    // 2: FIXED32 -> 15 78 56 34 12
    run(29'd2, 3'd2, 64'h10, 32'd0, 64'hDEADBEEF_12345678, 0, -1, 0, -1);
    exp_q = '{8'h15, 8'h78, 8'h56, 8'h34, 8'h12};
    chk_bytes("t2");
    chk("t2 mem_addr", paddr, 64'h110);
    chk("t2 total", 64'(total_bytes), 8);

    // 3: NESTED len 300 -> 82 01 AC 02, no read
    run(29'd16, 3'd5, 64'h0, 32'd300, 64'h0, 0, -1, 0, -1);
    exp_q = '{8'h82, 8'h01, 8'hAC, 8'h02};
    chk_bytes("t3");
    chk("t3 n_req", 64'(n_req), 0);
    chk("t3 n_done", 64'(n_done), 1);
    chk("t3 total", 64'(total_bytes), 12);

    // 4: end marker and reserved type
    run(29'd0, 3'd0, 64'h0, 32'd0, 64'h0, 0, -1, 0, -1);
    chk("t4a nbytes", 64'(got.size()), 0);
    chk("t4a n_req", 64'(n_req), 0);
    chk("t4a done_c", 64'(done_c), 1);
    chk("t4a err", 64'(err), 0);
    run(29'd3, 3'd7, 64'h0, 32'd0, 64'h0, 0, -1, 0, -1);
    chk("t4b nbytes", 64'(got.size()), 0);
    chk("t4b n_req", 64'(n_req), 0);
    chk("t4b n_done", 64'(n_done), 1);
    chk("t4b err", 64'(err), 1);

    // 5: late grant + mid-stream stall, 2^64-1 -> 08 FF*9 01
    run(29'd1, 3'd0, 64'h8, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4, 4, 3, -1);
    exp_q = '{8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    chk_bytes("t5");
    chk("t5 n_req", 64'(n_req), 5);
    chk("t5 addr held", 64'(addr_bad), 0);
    chk("t5 mem_addr", paddr, 64'h108);
    chk("t5 byte held", 64'(hold_bad), 0);
    chk("t5 stalls", 64'(stall_left), 0);
    chk("t5 n_done", 64'(n_done), 1);
    chk("t5 err sticky", 64'(err), 1);
    chk("t5 total", 64'(total_bytes), 23);

    // 6: reset mid-VAL, then test 1 again
    run(29'd1, 3'd0, 64'h8, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, 0, 6);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (ser_done || out_valid) n_done++;
    end
    chk("t6 quiet in reset", 64'(n_done), 0);
    reset = 1;
    run(29'd1, 3'd0, 64'h8, 32'd0, 64'd150, 0, -1, 0, -1);
    exp_q = '{8'h08, 8'h96, 8'h01};
    chk_bytes("t6");
    chk("t6 n_done", 64'(n_done), 1);
    chk("t6 total", 64'(total_bytes), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
